hazard_scoreboard: RTL

//  Issue-side counterpart of the EX/MEM/WB forwarding path. Per-register scoreboard that records
//  the cycles left until each in-flight destination's result is forwardable, and stalls ID issue
//  on RAW/WAW conflicts the bypass network cannot yet cover (load-use, multi-cycle ops).

---
 rtl/hazard_scoreboard.sv | 112 +++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scoreboard
//  Description : ID-stage per-register latency scoreboard. Tracks cycles left
//                until each in-flight destination becomes forwardable and
//                stalls issue on RAW/WAW hazards the bypass network cannot
//                cover yet (load-use, multi-cycle ops).
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int CW   = 3,
    parameter int SCW  = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rs,
    input  logic [AW-1:0]   issue_rt,
    input  logic            issue_use_rt,
    input  logic            issue_regwrite,
    input  logic [AW-1:0]   issue_rd,
    input  logic [CW-1:0]   issue_lat,
    input  logic            squash,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_rd,
    output logic            issue_stall,
    output logic            issue_fire,
    output logic [NREG-1:0] pending,
    output logic [SCW-1:0]  stall_cycles
);

    // Remaining-latency counter per register; entry 0 is never written
    // non-zero, so it stays at its reset value of zero.
    logic [CW-1:0]   r_cnt      [NREG];
    logic [CW-1:0]   w_cnt_nxt  [NREG];
    logic [NREG-1:0] r_pending;
    logic [SCW-1:0]  r_stall_cycles;

    logic [CW-1:0]   w_cnt_rs;
    logic [CW-1:0]   w_cnt_rt;
    logic [CW-1:0]   w_cnt_rd;
    logic            w_raw_a;
    logic            w_raw_b;
    logic            w_waw;
    logic            w_req;

    // Hazard lookups use only registered counter state, so the stall decision
    // never depends on this cycle's own update.
    assign w_cnt_rs = r_cnt[issue_rs];
    assign w_cnt_rt = r_cnt[issue_rt];
    assign w_cnt_rd = r_cnt[issue_rd];

    assign w_raw_a = (w_cnt_rs != '0);
    assign w_raw_b = issue_use_rt & (w_cnt_rt != '0);
    // A younger write may issue once the older one lands no later than it.
    assign w_waw   = issue_regwrite & (issue_rd != '0) & (w_cnt_rd > issue_lat);

    // A squashed instruction neither stalls nor fires.
    assign w_req       = issue_valid & ~squash;
    assign issue_stall = w_req & (w_raw_a | w_raw_b | w_waw);
    assign issue_fire  = w_req & ~(w_raw_a | w_raw_b | w_waw);

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_cnt
            if (gi == 0) begin : g_zero
                assign w_cnt_nxt[gi] = '0;
            end else begin : g_live
                logic w_set;
                logic w_clr;
                assign w_set = issue_fire & issue_regwrite & (issue_rd == AW'(gi));
                assign w_clr = wb_valid & (wb_rd == AW'(gi));
                // New issue beats early completion, which beats countdown.
                assign w_cnt_nxt[gi] = w_set                ? issue_lat :
                                       w_clr                ? '0 :
                                       (r_cnt[gi] != '0)    ? r_cnt[gi] - CW'(1) :
                                                              r_cnt[gi];
            end
        end
    endgenerate

    // Counter and pending-flag state; pending mirrors the new counter value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                r_cnt[r] <= '0;
            end
            r_pending <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                r_cnt[r]     <= w_cnt_nxt[r];
                r_pending[r] <= (w_cnt_nxt[r] != '0);
            end
        end
    end

    // Saturating count of cycles spent stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
        end else if (issue_stall && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + SCW'(1);
        end
    end

    assign pending      = r_pending;
    assign stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire
